benes_network: RTL and testbench



---
 rtl/xbar_if.sv | 29 ++
 rtl/benes_network.sv | 103 ++++++++++
 tb/tb_benes_network.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_if.sv
// ---------------------------------------------------------------------------
// xbar_if
// Lane bundle shared by the crossbar subsystem. Carries the interface clock,
// the asynchronous active-low reset and the two unpacked lane arrays.
//
// Ports / members:
//   clk    input   interface clock (single domain)
//   n_rst  input   asynchronous active-low reset
//   in     SIZE x DWIDTH lanes into the crossbar block
//   out    SIZE x DWIDTH lanes out of the crossbar block (registered there)
// ---------------------------------------------------------------------------
interface xbar_if #(
    parameter int SIZE   = 32,
    parameter int DWIDTH = 16
) (
    input logic clk,
    input logic n_rst
);
    logic [DWIDTH-1:0] in  [SIZE];
    logic [DWIDTH-1:0] out [SIZE];

    // View taken by the permutation block: it consumes in, produces out.
    modport dut (
        input  clk,
        input  n_rst,
        input  in,
        output out
    );
endinterface

// File: rtl/benes_network.sv
// ---------------------------------------------------------------------------
// benes_network
// Rearrangeable Benes permutation network. SIZE lanes of DWIDTH bits pass
// through STAGES = 2*log2(SIZE)-1 columns of 2x2 switches and are captured
// in an output register one clock later. The switch settings come in from
// outside; the block does no routing computation of its own.
//
// Ports:
//   xif          xbar_if.dut  clk, n_rst (async active-low), in[], out[]
//   control_bit  input [BITWIDTH-1:0]  bit s*SIZE/2+j drives switch j of
//                stage s; 0 = straight, 1 = cross
// ---------------------------------------------------------------------------
module benes_network #(
    parameter  int SIZE     = 32,
    parameter  int DWIDTH   = 16,
    localparam int TAGWIDTH = $clog2(SIZE),
    localparam int STAGES   = 2 * TAGWIDTH - 1,
    localparam int BITWIDTH = STAGES * SIZE / 2
) (
    xbar_if.dut                 xif,
    input  logic [BITWIDTH-1:0] control_bit
);

    // Position of the stage-s output that feeds input position p of stage
    // s+1. Every stage is viewed as blocks of contiguous positions; a block
    // of size B is one recursive Benes sub-network at that depth.
    //   Input half (s < TAGWIDTH-1): block size B = SIZE >> s. Upper switch
    //   outputs (even positions) go to the upper sub-network in order, lower
    //   outputs (odd positions) to the lower sub-network in order.
    //   Output half: the mirror image; B is the size of the block whose
    //   output column is stage s+1.
    function automatic int src_idx(input int s, input int p);
        int blk;
        int base;
        int loc;
        int res;
        res = 0;
        if (s < TAGWIDTH - 1) begin
            blk  = SIZE >> s;
            base = (p / blk) * blk;
            loc  = p - base;
            if (loc < blk / 2) res = base + 2 * loc;
            else               res = base + 2 * (loc - blk / 2) + 1;
        end else begin
            blk  = SIZE >> (STAGES - 2 - s);
            base = (p / blk) * blk;
            loc  = p - base;
            if ((loc % 2) == 0) res = base + loc / 2;
            else                res = base + blk / 2 + loc / 2;
        end
        return res;
    endfunction

    logic [DWIDTH-1:0] w_final [SIZE];
    logic [DWIDTH-1:0] r_out   [SIZE];

    genvar gi, gp, gj;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Per-stage arrays keep each column a separate signal, so the
            // chain of stages never looks combinationally circular.
            logic [DWIDTH-1:0] w_sw_in  [SIZE];
            logic [DWIDTH-1:0] w_sw_out [SIZE];

            for (gp = 0; gp < SIZE; gp++) begin : g_link
                if (gi == 0) begin : g_first
                    assign w_sw_in[gp] = xif.in[gp];
                end else begin : g_inner
                    assign w_sw_in[gp] = g_stage[gi-1].w_sw_out[src_idx(gi - 1, gp)];
                end
            end

            for (gj = 0; gj < SIZE / 2; gj++) begin : g_sw
                logic w_cross;
                assign w_cross             = control_bit[gi * (SIZE / 2) + gj];
                assign w_sw_out[2 * gj]     = w_cross ? w_sw_in[2 * gj + 1] : w_sw_in[2 * gj];
                assign w_sw_out[2 * gj + 1] = w_cross ? w_sw_in[2 * gj]     : w_sw_in[2 * gj + 1];
            end

            if (gi == STAGES - 1) begin : g_last
                for (gp = 0; gp < SIZE; gp++) begin : g_tap
                    assign w_final[gp] = w_sw_out[gp];
                end
            end
        end
    endgenerate

    // Output register: the only state in the block.
    always_ff @(posedge xif.clk or negedge xif.n_rst) begin
        if (!xif.n_rst) begin
            for (int i = 0; i < SIZE; i++) r_out[i] <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) r_out[i] <= w_final[i];
        end
    end

    generate
        for (gp = 0; gp < SIZE; gp++) begin : g_out
            assign xif.out[gp] = r_out[gp];
        end
    endgenerate

endmodule

// File: tb/tb_benes_network.sv
// ---------------------------------------------------------------------------
// tb_benes_network
// Directed and random stimulus for benes_network (SIZE=32, DWIDTH=16).
// A block-recursive model of the network predicts every registered output;
// literal expectations pin the model on a few hand-traced settings.
// ---------------------------------------------------------------------------
module tb_benes_network;
    localparam int SIZE = 32;
    localparam int DW   = 16;
    localparam int TW   = 5;
    localparam int ST   = 2 * TW - 1;
    localparam int BW   = ST * SIZE / 2;

    typedef logic [DW-1:0] lane_t;
    typedef lane_t lanes_t [SIZE];

    logic          clk   = 1'b0;
    logic          n_rst = 1'b0;
    logic [BW-1:0] control_bit;
    int            checks = 0;
    int            errors = 0;
    bit            perm_check = 1'b0;

    xbar_if #(.SIZE(SIZE), .DWIDTH(DW)) xif (.clk(clk), .n_rst(n_rst));

    benes_network #(.SIZE(SIZE), .DWIDTH(DW)) dut (
        .xif         (xif),
        .control_bit (control_bit)
    );

    always #5 clk = ~clk;

    // Network model: walk the recursion level by level. At depth d the lanes
    // sit in contiguous blocks of SIZE>>d. Going in, each block's switches
    // split the lanes into an upper half and a lower half; the innermost
    // level is one switch; coming out, each block merges its halves back.
    function automatic lanes_t model(input lanes_t x, input logic [BW-1:0] c);
        lanes_t cur;
        lanes_t nxt;
        lane_t  up;
        lane_t  lo;
        logic   sw;
        int     blk;
        cur = x;
        nxt = x;
        for (int d = 0; d < TW; d++) begin
            blk = SIZE >> d;
            for (int base = 0; base < SIZE; base += blk) begin
                for (int k = 0; k < blk / 2; k++) begin
                    sw = c[d * (SIZE / 2) + base / 2 + k];
                    up = sw ? cur[base + 2*k + 1] : cur[base + 2*k];
                    lo = sw ? cur[base + 2*k]     : cur[base + 2*k + 1];
                    if (blk == 2) begin
                        nxt[base]     = up;
                        nxt[base + 1] = lo;
                    end else begin
                        nxt[base + k]           = up;
                        nxt[base + blk / 2 + k] = lo;
                    end
                end
            end
            cur = nxt;
        end
        for (int d = TW - 2; d >= 0; d--) begin
            blk = SIZE >> d;
            for (int base = 0; base < SIZE; base += blk) begin
                for (int k = 0; k < blk / 2; k++) begin
                    sw = c[(ST - 1 - d) * (SIZE / 2) + base / 2 + k];
                    up = cur[base + k];
                    lo = cur[base + blk / 2 + k];
                    nxt[base + 2*k]     = sw ? lo : up;
                    nxt[base + 2*k + 1] = sw ? up : lo;
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    task automatic check_vec(input string name, input lanes_t exp);
        int d;
        d = -1;
        for (int i = 0; i < SIZE; i++) begin
            if (d < 0 && xif.out[i] !== exp[i]) d = i;
        end
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL %s lane %0d got %h want %h (t=%0t)", name, d, xif.out[d], exp[d], $time);
        end
    endtask

    task automatic set_in(input lanes_t v);
        for (int i = 0; i < SIZE; i++) xif.in[i] = v[i];
    endtask

    // One directed transaction: drive at negedge, check after the next edge.
    task automatic apply(input string name, input logic [BW-1:0] c,
                         input lanes_t v, input lanes_t exp);
        @(negedge clk);
        control_bit = c;
        set_in(v);
        @(posedge clk);
        #2;
        check_vec(name, exp);
        $display("vec %-12s out[0..3] = %h %h %h %h", name,
                 xif.out[0], xif.out[1], xif.out[2], xif.out[3]);
    endtask

    // Compare process: every cycle, predict the register from what was on
    // the inputs at the edge and check it just after.
    initial begin
        lanes_t        xin;
        lanes_t        exp;
        logic [BW-1:0] c;
        int            seen [SIZE];
        bit            ok;
        forever begin
            @(posedge clk);
            for (int i = 0; i < SIZE; i++) xin[i] = xif.in[i];
            c = control_bit;
            if (n_rst) exp = model(xin, c);
            else       exp = '{default: '0};
            #1;
            if (!n_rst) exp = '{default: '0};
            check_vec("cycle", exp);
            if (perm_check) begin
                for (int i = 0; i < SIZE; i++) seen[i] = 0;
                ok = 1'b1;
                for (int i = 0; i < SIZE; i++) begin
                    if (xif.out[i] < lane_t'(SIZE)) seen[int'(xif.out[i])]++;
                    else ok = 1'b0;
                end
                for (int i = 0; i < SIZE; i++) if (seen[i] != 1) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL permutation out[0]=%h out[31]=%h not a bijection of 0..31 (t=%0t)",
                             xif.out[0], xif.out[SIZE-1], $time);
                end
            end
        end
    end

    initial begin
        lanes_t        idv;
        lanes_t        zero;
        lanes_t        dat;
        lanes_t        exp;
        lanes_t        rnd;
        logic [BW-1:0] c;

        for (int i = 0; i < SIZE; i++) begin
            idv[i]  = lane_t'(i);
            zero[i] = '0;
            dat[i]  = lane_t'(16'hA5A5 ^ (i * 16'h0421));
        end
        set_in(idv);
        control_bit = '1;

        // Reset: zero before and across a clock edge, and after release
        // until the next edge.
        #3;
        check_vec("reset_async", zero);
        @(posedge clk);
        #2;
        check_vec("reset_hold", zero);
        @(negedge clk);
        control_bit = '0;
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        check_vec("reset_release", zero);
        @(posedge clk);
        #2;
        check_vec("post_reset", idv);

        // Directed settings with hand-traced results.
        apply("identity", '0, idv, idv);
        apply("ident_data", '0, dat, dat);

        c = '0;
        c[BW-1 -: SIZE/2] = '1;
        for (int j = 0; j < SIZE / 2; j++) begin
            exp[2*j]     = lane_t'(2*j + 1);
            exp[2*j + 1] = lane_t'(2*j);
        end
        apply("last_cross", c, idv, exp);

        c = '0;
        c[SIZE/2-1:0] = '1;
        apply("first_cross", c, idv, exp);

        c[BW-1 -: SIZE/2] = '1;
        apply("both_cross", c, idv, idv);

        // Middle switch 0 sees in[0] and in[16] and swaps just those two.
        c = '0;
        c[(TW - 1) * (SIZE / 2)] = 1'b1;
        exp = idv;
        exp[0]  = lane_t'(16);
        exp[16] = lane_t'(0);
        apply("mid_sw0", c, idv, exp);

        // Random control vectors on identity data: model match plus
        // bijection check every cycle.
        perm_check = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            for (int b = 0; b < BW; b++) control_bit[b] = 1'($urandom_range(0, 1));
            set_in(idv);
        end

        // Back-to-back random data and control, with a reset pulse between
        // edges partway through.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            perm_check = 1'b0;
            for (int b = 0; b < BW; b++) control_bit[b] = 1'($urandom_range(0, 1));
            for (int i = 0; i < SIZE; i++) rnd[i] = lane_t'($urandom);
            set_in(rnd);
            if (n == 10) begin
                #1;
                n_rst = 1'b0;
                #1;
                check_vec("reset_midrun", zero);
                #1;
                n_rst = 1'b1;
            end
        end

        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
